// File: rtl/seg7_scan_driver.sv
// Two-digit 7-segment scan driver: double-buffered segment codes, blank gaps
// between digits, optional leading-zero blanking on the tens digit.
module seg7_scan_driver #(
  parameter int unsigned DWELL          = 1000,
  parameter int unsigned GAP            = 2,
  parameter logic [7:0]  ZERO_CODE      = 8'b0011_1111,
  parameter bit          BLANK_LZ       = 1'b1,
  parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       load,
  input  logic [7:0] digit_hi,
  input  logic [7:0] digit_lo,
  output logic [7:0] seg,
  output logic [1:0] an,
  output logic       frame_done
);

  localparam int unsigned CNT_W      = 16;
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'((GAP > 0) ? GAP - 1 : 0);
  localparam bit               HAS_GAP    = (GAP != 0);
  localparam logic [7:0]       SEG_BLANK  = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;

  typedef enum logic [2:0] {
    ST_OFF     = 3'd0,
    ST_SHOW_HI = 3'd1,
    ST_GAP_HI  = 3'd2,
    ST_SHOW_LO = 3'd3,
    ST_GAP_LO  = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       shadow_hi_q, shadow_hi_d, shadow_lo_q, shadow_lo_d;
  logic [7:0]       disp_hi_q, disp_hi_d, disp_lo_q, disp_lo_d;
  logic [7:0]       seg_q, seg_d;
  logic [1:0]       an_q, an_d;
  logic             frame_done_q, frame_done_d;

  function automatic logic [7:0] seg_drive(input logic [7:0] code);
    return SEG_ACTIVE_LOW ? ~code : code;
  endfunction

  // Next state, counter, buffers and outputs all derived from the next state
  // so outputs change on the same edge as the state register.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + CNT_W'(1);
    shadow_hi_d  = load ? digit_hi : shadow_hi_q;
    shadow_lo_d  = load ? digit_lo : shadow_lo_q;
    disp_hi_d    = disp_hi_q;
    disp_lo_d    = disp_lo_q;
    frame_done_d = 1'b0;
    seg_d        = SEG_BLANK;
    an_d         = 2'b11;

    if (!en) begin
      state_d = ST_OFF;
    end else begin
      unique case (state_q)
        ST_OFF:     state_d = ST_SHOW_HI;
        ST_SHOW_HI: if (cnt_q == DWELL_LAST) state_d = HAS_GAP ? ST_GAP_HI : ST_SHOW_LO;
        ST_GAP_HI:  if (cnt_q == GAP_LAST)   state_d = ST_SHOW_LO;
        ST_SHOW_LO: if (cnt_q == DWELL_LAST) state_d = HAS_GAP ? ST_GAP_LO : ST_SHOW_HI;
        ST_GAP_LO:  if (cnt_q == GAP_LAST)   state_d = ST_SHOW_HI;
        default:    state_d = ST_OFF;
      endcase
    end

    if (state_d != state_q || state_d == ST_OFF) cnt_d = '0;

    // Frame boundary: swap in the buffered codes (pre-edge shadow, no bypass).
    if (state_d == ST_SHOW_HI && state_q != ST_SHOW_HI) begin
      disp_hi_d    = shadow_hi_q;
      disp_lo_d    = shadow_lo_q;
      frame_done_d = (state_q == ST_SHOW_LO) || (state_q == ST_GAP_LO);
    end

    if (state_d == ST_SHOW_HI) begin
      if (!(BLANK_LZ && disp_hi_d == ZERO_CODE)) begin
        an_d  = 2'b01;
        seg_d = seg_drive(disp_hi_d);
      end
    end else if (state_d == ST_SHOW_LO) begin
      an_d  = 2'b10;
      seg_d = seg_drive(disp_lo_d);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_OFF;
      cnt_q        <= '0;
      shadow_hi_q  <= 8'h00;
      shadow_lo_q  <= 8'h00;
      disp_hi_q    <= 8'h00;
      disp_lo_q    <= 8'h00;
      seg_q        <= SEG_BLANK;
      an_q         <= 2'b11;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shadow_hi_q  <= shadow_hi_d;
      shadow_lo_q  <= shadow_lo_d;
      disp_hi_q    <= disp_hi_d;
      disp_lo_q    <= disp_lo_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: two instances (gap/LZ-blank and
// no-gap/no-blank) share stimulus; a frame-position model predicts outputs.
module tb_seg7_scan_driver;

  localparam logic [7:0] ZC = 8'b0011_1111;

  typedef struct packed {
    logic [7:0] seg;
    logic [1:0] an;
    logic       fd;
  } out_t;

  typedef struct packed {
    out_t a;
    out_t b;
  } pair_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       load = 1'b0;
  logic [7:0] digit_hi = 8'h00;
  logic [7:0] digit_lo = 8'h00;
  logic [7:0] seg_a, seg_b;
  logic [1:0] an_a, an_b;
  logic       fd_a, fd_b;

  always #5 clk = ~clk;

  seg7_scan_driver #(.DWELL(4), .GAP(1), .ZERO_CODE(ZC), .BLANK_LZ(1'b1), .SEG_ACTIVE_LOW(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .digit_hi(digit_hi), .digit_lo(digit_lo),
    .seg(seg_a), .an(an_a), .frame_done(fd_a));

  seg7_scan_driver #(.DWELL(4), .GAP(0), .ZERO_CODE(ZC), .BLANK_LZ(1'b0), .SEG_ACTIVE_LOW(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .digit_hi(digit_hi), .digit_lo(digit_lo),
    .seg(seg_b), .an(an_b), .frame_done(fd_b));

  // Reference model: position within a frame of 2*(DWELL+GAP) cycles.
  int         m_dwell [2] = '{4, 4};
  int         m_gap   [2] = '{1, 0};
  bit         m_blz   [2] = '{1'b1, 1'b0};
  bit         m_run   [2];
  int         m_pos   [2];
  bit         m_fd    [2];
  logic [7:0] m_dhi   [2];
  logic [7:0] m_dlo   [2];
  logic [7:0] m_shi, m_slo;

  pair_t exp_q[$];
  int    n_total = 0;
  int    n_pass  = 0;

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_run[k] = 1'b0; m_pos[k] = 0; m_fd[k] = 1'b0;
      m_dhi[k] = 8'h00; m_dlo[k] = 8'h00;
    end
    m_shi = 8'h00; m_slo = 8'h00;
  endtask

  task automatic model_step();
    if (!rst_n) begin
      model_reset();
    end else begin
      for (int k = 0; k < 2; k++) begin
        m_fd[k] = 1'b0;
        if (!en) begin
          m_run[k] = 1'b0;
        end else if (!m_run[k]) begin
          m_run[k] = 1'b1; m_pos[k] = 0;
          m_dhi[k] = m_shi; m_dlo[k] = m_slo;
        end else begin
          m_pos[k] = (m_pos[k] + 1) % (2 * (m_dwell[k] + m_gap[k]));
          if (m_pos[k] == 0) begin
            m_fd[k] = 1'b1; m_dhi[k] = m_shi; m_dlo[k] = m_slo;
          end
        end
      end
      if (load) begin
        m_shi = digit_hi; m_slo = digit_lo;
      end
    end
  endtask

  function automatic out_t model_out(input int k);
    out_t o;
    o.seg = 8'hFF; o.an = 2'b11; o.fd = m_fd[k];
    if (m_run[k]) begin
      if (m_pos[k] < m_dwell[k]) begin
        if (!(m_blz[k] && m_dhi[k] == ZC)) begin
          o.an = 2'b01; o.seg = ~m_dhi[k];
        end
      end else if (m_pos[k] >= m_dwell[k] + m_gap[k] && m_pos[k] < 2 * m_dwell[k] + m_gap[k]) begin
        o.an = 2'b10; o.seg = ~m_dlo[k];
      end
    end
    return o;
  endfunction

  task automatic tick(input bit r, input bit e, input bit l, input logic [7:0] h, input logic [7:0] lo);
    pair_t p;
    @(negedge clk);
    rst_n = r; en = e; load = l; digit_hi = h; digit_lo = lo;
    @(posedge clk);
    model_step();
    p.a = model_out(0);
    p.b = model_out(1);
    exp_q.push_back(p);
  endtask

  task automatic idle_on();
    tick(1'b1, 1'b1, 1'b0, 8'($urandom), 8'($urandom));
  endtask

  // Advance until instance A's model sits at the given frame position.
  task automatic adv_to(input int t);
    for (int n = 0; n < 20 && !(m_run[0] && m_pos[0] == t); n++) idle_on();
  endtask

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] expv);
    n_total++;
    if (act === expv) n_pass++;
    else $display("FAIL %s dut%0d: got %0h expected %0h at %0t", nm, k, act, expv, $time);
  endtask

  // Monitor: compare each registered output set against the scoreboard head;
  // with nothing queued and reset asserted, outputs must already be blank.
  initial begin
    pair_t p;
    forever begin
      @(negedge clk or negedge rst_n);
      #1;
      if (exp_q.size() > 0) begin
        p = exp_q.pop_front();
        chk("seg", 0, 32'(seg_a), 32'(p.a.seg));
        chk("an",  0, 32'(an_a),  32'(p.a.an));
        chk("frame_done", 0, 32'(fd_a), 32'(p.a.fd));
        chk("seg", 1, 32'(seg_b), 32'(p.b.seg));
        chk("an",  1, 32'(an_b),  32'(p.b.an));
        chk("frame_done", 1, 32'(fd_b), 32'(p.b.fd));
      end else if (!rst_n) begin
        chk("rst_seg", 0, 32'(seg_a), 32'hFF);
        chk("rst_an",  0, 32'(an_a),  32'h3);
        chk("rst_fd",  0, 32'(fd_a),  32'h0);
        chk("rst_seg", 1, 32'(seg_b), 32'hFF);
        chk("rst_an",  1, 32'(an_b),  32'h3);
        chk("rst_fd",  1, 32'(fd_b),  32'h0);
      end
    end
  end

  initial begin
    model_reset();
    repeat (4) tick(1'b0, 1'b0, 1'b1, 8'($urandom), 8'($urandom));
    tick(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    repeat (12) idle_on();

    tick(1'b1, 1'b0, 1'b1, 8'b0000_0110, 8'b0101_1011);
    repeat (22) idle_on();

    tick(1'b1, 1'b1, 1'b1, ZC, 8'b0111_1101);
    repeat (22) idle_on();

    adv_to(6);
    tick(1'b1, 1'b1, 1'b1, 8'b0100_1111, 8'b0110_0110);
    repeat (12) idle_on();

    adv_to(9);
    tick(1'b1, 1'b1, 1'b1, 8'b0110_1101, 8'b0000_0111);
    repeat (22) idle_on();

    adv_to(1);
    tick(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    tick(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    repeat (14) idle_on();

    for (int i = 0; i < 300; i++) begin
      logic [7:0] h;
      h = ($urandom_range(0, 3) == 0) ? ZC : 8'($urandom);
      tick(1'b1, $urandom_range(0, 39) != 0, $urandom_range(0, 7) == 0, h, 8'($urandom));
    end

    adv_to(6);
    @(negedge clk);
    #2 rst_n = 1'b0;
    model_reset();
    #4;
    tick(1'b0, 1'b1, 1'b1, 8'($urandom), 8'($urandom));
    tick(1'b1, 1'b1, 1'b0, 8'h00, 8'h00);
    repeat (14) idle_on();

    @(negedge clk);
    #3;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
